// File: rtl/usb_host_linksig_pkg.sv
// rtl/usb_host_linksig_pkg.sv - shared state, command and line-state definitions for usb_host_linksig
package usb_host_linksig_pkg;

    localparam logic [2:0] ST_DETACHED   = 3'd0;
    localparam logic [2:0] ST_IDLE       = 3'd1;
    localparam logic [2:0] ST_BUS_RESET  = 3'd2;
    localparam logic [2:0] ST_ACTIVE     = 3'd3;
    localparam logic [2:0] ST_SUSPENDED  = 3'd4;
    localparam logic [2:0] ST_RESUME_K   = 3'd5;
    localparam logic [2:0] ST_RESUME_EOP = 3'd6;
    localparam logic [2:0] ST_RELEASE    = 3'd7;

    typedef enum logic [2:0] {
        S_DETACHED   = ST_DETACHED,
        S_IDLE       = ST_IDLE,
        S_BUS_RESET  = ST_BUS_RESET,
        S_ACTIVE     = ST_ACTIVE,
        S_SUSPENDED  = ST_SUSPENDED,
        S_RESUME_K   = ST_RESUME_K,
        S_RESUME_EOP = ST_RESUME_EOP,
        S_RELEASE    = ST_RELEASE
    } link_sig_state_e;

    typedef enum logic [1:0] {
        CMD_RESET   = 2'd0,
        CMD_SUSPEND = 2'd1,
        CMD_RESUME  = 2'd2,
        CMD_RSVD    = 2'd3
    } link_sig_cmd_e;

    // Line states packed as {dp, dn}
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;

endpackage

// File: rtl/usb_host_linksig_sofgen.sv
// rtl/usb_host_linksig_sofgen.sv - frame timer, SOF request/ack handshake and frame counter
module usb_host_linksig_sofgen
    import usb_host_linksig_pkg::*;
#(
    parameter int SOF_PERIOD_US = 1000
) (
    input  logic        clk_48mhz_i,
    input  logic        rst_i,
    input  logic        us_tick_i,
    input  logic        active_i,
    input  logic        stay_i,
    input  logic        clear_i,
    input  logic        sof_ack_i,
    output logic        sof_req_o,
    output logic [10:0] frame_num_o
);

    localparam logic [15:0] FRAME_LAST = 16'(SOF_PERIOD_US - 1);

    logic [15:0] frame_tmr_q, frame_tmr_d;
    logic        sof_req_q, sof_req_d;
    logic [10:0] frame_num_q, frame_num_d;
    logic        wrap;

    // Frame timer runs only while Active is both current and next state, so a
    // tick on the entry cycle is not counted and leaving drops any pending SOF.
    always_comb begin
        wrap        = 1'b0;
        frame_tmr_d = frame_tmr_q;
        sof_req_d   = sof_req_q;
        frame_num_d = frame_num_q;
        if (!(active_i && stay_i)) begin
            frame_tmr_d = '0;
            sof_req_d   = 1'b0;
        end else begin
            if (us_tick_i) begin
                if (frame_tmr_q == FRAME_LAST) begin
                    frame_tmr_d = '0;
                    wrap        = 1'b1;
                end else begin
                    frame_tmr_d = frame_tmr_q + 16'd1;
                end
            end
            // A wrap while a request is outstanding does not queue another one
            if (sof_ack_i && sof_req_q) begin
                sof_req_d   = 1'b0;
                frame_num_d = frame_num_q + 11'd1;
            end else if (wrap) begin
                sof_req_d = 1'b1;
            end
        end
        if (clear_i) begin
            frame_num_d = '0;
        end
    end

    // State registers
    always_ff @(posedge clk_48mhz_i) begin
        if (rst_i) begin
            frame_tmr_q <= '0;
            sof_req_q   <= 1'b0;
            frame_num_q <= '0;
        end else begin
            frame_tmr_q <= frame_tmr_d;
            sof_req_q   <= sof_req_d;
            frame_num_q <= frame_num_d;
        end
    end

    assign sof_req_o   = sof_req_q;
    assign frame_num_o = frame_num_q;

endmodule

// File: rtl/usb_host_linksig.sv
// rtl/usb_host_linksig.sv - host USB FS link signalling (reset/suspend/resume/SOF); option USB_HOST_LINKSIG_WAKE_EN
module usb_host_linksig
    import usb_host_linksig_pkg::*;
#(
    parameter int RESET_US      = 10000,
    parameter int RESUME_US     = 20000,
    parameter int SOF_PERIOD_US = 1000,
    parameter int LS_BIT_CYC    = 32
) (
    input  logic        clk_48mhz_i,
    input  logic        rst_i,
    input  logic        us_tick_i,
    input  logic        connect_i,
    input  logic        cmd_valid_i,
    input  logic [1:0]  cmd_i,
    output logic        cmd_ready_o,
    output logic        done_o,
    output logic        sof_req_o,
    input  logic        sof_ack_i,
    output logic [10:0] frame_num_o,
    output logic        usb_dp_o,
    output logic        usb_dn_o,
    output logic        usb_oe_o,
    output logic        sig_active_o,
    output logic        wake_o,
    input  logic        usb_dp_i,
    input  logic        usb_dn_i,
    output logic [2:0]  state_o
);

    localparam logic [15:0] RESET_LAST  = 16'(RESET_US - 1);
    localparam logic [15:0] RESUME_LAST = 16'(RESUME_US - 1);
    localparam logic [6:0]  J_LAST      = 7'(LS_BIT_CYC - 1);
    localparam logic [6:0]  EOP_LAST    = 7'(2 * LS_BIT_CYC - 1);

    link_sig_state_e state_q, state_d;
    logic [15:0]     us_tmr_q, us_tmr_d;
    logic [6:0]      cyc_tmr_q, cyc_tmr_d;
    logic            cmd_accept;
    logic            wake_det;
    logic            done;
    logic [1:0]      line;
    logic            oe;

    assign cmd_ready_o = (state_q == S_IDLE) || (state_q == S_ACTIVE) || (state_q == S_SUSPENDED);
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;

`ifdef USB_HOST_LINKSIG_WAKE_EN
    logic [2:0] kfilt_q, kfilt_d;
    logic       rx_k;

    assign rx_k = ({usb_dp_i, usb_dn_i} == LINE_K);

    // Remote wakeup needs 8 consecutive received K cycles while suspended
    always_comb begin
        kfilt_d  = 3'd0;
        wake_det = 1'b0;
        if (state_q == S_SUSPENDED && rx_k) begin
            if (kfilt_q == 3'd7) begin
                wake_det = 1'b1;
            end else begin
                kfilt_d = kfilt_q + 3'd1;
            end
        end
    end

    // K filter register
    always_ff @(posedge clk_48mhz_i) begin
        if (rst_i) begin
            kfilt_q <= 3'd0;
        end else begin
            kfilt_q <= kfilt_d;
        end
    end
`else
    logic unused_rx;
    assign unused_rx = usb_dp_i ^ usb_dn_i;
    assign wake_det  = 1'b0;
`endif

    // Link FSM; timers restart on every state change and detach overrides all
    always_comb begin
        state_d   = state_q;
        us_tmr_d  = us_tmr_q;
        cyc_tmr_d = cyc_tmr_q;
        done      = 1'b0;
        case (state_q)
            S_DETACHED: begin
                if (connect_i) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cmd_accept && cmd_i == CMD_RESET) state_d = S_BUS_RESET;
            end
            S_BUS_RESET: begin
                if (us_tick_i) begin
                    if (us_tmr_q == RESET_LAST) state_d = S_RELEASE;
                    else us_tmr_d = us_tmr_q + 16'd1;
                end
            end
            S_ACTIVE: begin
                if (cmd_accept && cmd_i == CMD_RESET) begin
                    state_d = S_BUS_RESET;
                end else if (cmd_accept && cmd_i == CMD_SUSPEND) begin
                    state_d = S_SUSPENDED;
                    done    = 1'b1;
                end
            end
            S_SUSPENDED: begin
                // A legal command takes priority over a same-cycle wake detection
                if (cmd_accept && cmd_i == CMD_RESET) state_d = S_BUS_RESET;
                else if (cmd_accept && cmd_i == CMD_RESUME) state_d = S_RESUME_K;
                else if (wake_det) state_d = S_RESUME_K;
            end
            S_RESUME_K: begin
                if (us_tick_i) begin
                    if (us_tmr_q == RESUME_LAST) state_d = S_RESUME_EOP;
                    else us_tmr_d = us_tmr_q + 16'd1;
                end
            end
            S_RESUME_EOP: begin
                if (cyc_tmr_q == EOP_LAST) state_d = S_RELEASE;
                else cyc_tmr_d = cyc_tmr_q + 7'd1;
            end
            S_RELEASE: begin
                if (cyc_tmr_q == J_LAST) begin
                    state_d = S_ACTIVE;
                    done    = 1'b1;
                end else begin
                    cyc_tmr_d = cyc_tmr_q + 7'd1;
                end
            end
            default: state_d = S_DETACHED;
        endcase
        if (state_d != state_q) begin
            us_tmr_d  = '0;
            cyc_tmr_d = '0;
        end
        if (!connect_i) begin
            state_d   = S_DETACHED;
            done      = 1'b0;
            us_tmr_d  = '0;
            cyc_tmr_d = '0;
        end
    end

    // FSM and timer registers
    always_ff @(posedge clk_48mhz_i) begin
        if (rst_i) begin
            state_q   <= S_DETACHED;
            us_tmr_q  <= '0;
            cyc_tmr_q <= '0;
        end else begin
            state_q   <= state_d;
            us_tmr_q  <= us_tmr_d;
            cyc_tmr_q <= cyc_tmr_d;
        end
    end

    // Line driver: the block owns the bus only in the signalling states
    always_comb begin
        line = LINE_SE0;
        oe   = 1'b0;
        case (state_q)
            S_BUS_RESET, S_RESUME_EOP: oe = 1'b1;
            S_RESUME_K: begin
                line = LINE_K;
                oe   = 1'b1;
            end
            S_RELEASE: begin
                line = LINE_J;
                oe   = 1'b1;
            end
            default: begin
                line = LINE_SE0;
                oe   = 1'b0;
            end
        endcase
    end

    usb_host_linksig_sofgen #(
        .SOF_PERIOD_US (SOF_PERIOD_US)
    ) u_sofgen (
        .clk_48mhz_i (clk_48mhz_i),
        .rst_i       (rst_i),
        .us_tick_i   (us_tick_i),
        .active_i    (state_q == S_ACTIVE),
        .stay_i      (state_d == S_ACTIVE),
        .clear_i     (state_d == S_DETACHED),
        .sof_ack_i   (sof_ack_i),
        .sof_req_o   (sof_req_o),
        .frame_num_o (frame_num_o)
    );

    assign usb_dp_o     = line[1];
    assign usb_dn_o     = line[0];
    assign usb_oe_o     = oe;
    assign sig_active_o = oe;
    assign done_o       = done;
    assign wake_o       = wake_det && connect_i;
    assign state_o      = state_q;

endmodule

// File: tb/tb_usb_host_linksig.sv
// tb/tb_usb_host_linksig.sv - self-checking bench for usb_host_linksig
module tb_usb_host_linksig;

    localparam int P = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        us_tick = 1'b0;
    logic        connect = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic        sof_ack = 1'b0;
    logic        rx_dp = 1'b1;
    logic        rx_dn = 1'b0;
    logic        cmd_ready_o, done_o, sof_req_o;
    logic [10:0] frame_num_o;
    logic        usb_dp_o, usb_dn_o, usb_oe_o, sig_active_o, wake_o;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;
    int m_ticks;
    logic m_req;
    int m_frame;
    int r_rst, r_k, r_eop, r_j, r_done, r_bad;

    typedef struct {
        logic [2:0] from;
        logic [1:0] c;
        logic       ready;
        logic       done;
        logic [2:0] nxt;
    } vec_t;
    vec_t tbl[11];

    always #5 clk = ~clk;

    usb_host_linksig #(
        .RESET_US(10), .RESUME_US(20), .SOF_PERIOD_US(P), .LS_BIT_CYC(32)
    ) dut (
        .clk_48mhz_i(clk), .rst_i(rst), .us_tick_i(us_tick), .connect_i(connect),
        .cmd_valid_i(cmd_valid), .cmd_i(cmd), .cmd_ready_o(cmd_ready_o), .done_o(done_o),
        .sof_req_o(sof_req_o), .sof_ack_i(sof_ack), .frame_num_o(frame_num_o),
        .usb_dp_o(usb_dp_o), .usb_dn_o(usb_dn_o), .usb_oe_o(usb_oe_o),
        .sig_active_o(sig_active_o), .wake_o(wake_o), .usb_dp_i(rx_dp), .usb_dn_i(rx_dn),
        .state_o(state_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        rst = 1'b1; connect = 1'b0; cmd_valid = 1'b0; sof_ack = 1'b0; us_tick = 1'b0;
        rx_dp = 1'b1; rx_dn = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        cmd_valid = 1'b1; cmd = c;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound);
        int n;
        n = 0;
        while (state_o !== s && n < bound) begin
            cyc();
            n++;
        end
        chk("wait_state", state_o, s);
    endtask

    task automatic go_idle();
        hard_reset();
        connect = 1'b1;
        cyc();
    endtask

    task automatic go_active();
        go_idle();
        us_tick = 1'b1;
        send_cmd(2'd0);
        wait_state(3'd3, 200);
        us_tick = 1'b0;
    endtask

    task automatic go_susp();
        go_active();
        send_cmd(2'd1);
    endtask

    // One Active cycle checked against the frame model, then the model advances
    task automatic sof_step(input logic tk, input logic ak);
        us_tick = tk; sof_ack = ak;
        @(negedge clk);
        chk("sof_cadence", {state_o, sof_req_o, frame_num_o}, {3'd3, m_req, m_frame[10:0]});
        if (tk) m_ticks++;
        if (ak && m_req) begin
            m_frame = (m_frame + 1) % 2048;
            m_req = 1'b0;
        end else if (tk && (m_ticks % P == 0)) begin
            m_req = 1'b1;
        end
        cyc();
    endtask

    // Walk a signalling sequence until the link reaches Active or Detached
    task automatic run_signal(input bit alt);
        int guard;
        logic [2:0] exp_line;
        guard = 0; r_rst = 0; r_k = 0; r_eop = 0; r_j = 0; r_done = 0; r_bad = 0;
        while (state_o != 3'd3 && state_o != 3'd0 && guard < 5000) begin
            us_tick = alt ? ~us_tick : 1'b1;
            @(negedge clk);
            if (done_o) r_done++;
            case (state_o)
                3'd2: begin if (us_tick) r_rst++; exp_line = 3'b001; end
                3'd5: begin if (us_tick) r_k++; exp_line = 3'b011; end
                3'd6: begin r_eop++; exp_line = 3'b001; end
                3'd7: begin r_j++; exp_line = 3'b101; end
                default: exp_line = 3'b000;
            endcase
            if ({usb_dp_o, usb_dn_o, usb_oe_o} != exp_line || sig_active_o != usb_oe_o) r_bad++;
            cyc();
            guard++;
        end
        us_tick = 1'b0;
        chk("sig_end_state", state_o, 3'd3);
        chk("sig_end_oe", {usb_oe_o, sig_active_o}, 2'b00);
    endtask

    initial begin
        int rises, n, nb, nw;
        logic prev;

        tbl[0]  = '{3'd1, 2'd1, 1'b1, 1'b0, 3'd1};
        tbl[1]  = '{3'd1, 2'd2, 1'b1, 1'b0, 3'd1};
        tbl[2]  = '{3'd1, 2'd3, 1'b1, 1'b0, 3'd1};
        tbl[3]  = '{3'd1, 2'd0, 1'b1, 1'b0, 3'd2};
        tbl[4]  = '{3'd3, 2'd2, 1'b1, 1'b0, 3'd3};
        tbl[5]  = '{3'd3, 2'd3, 1'b1, 1'b0, 3'd3};
        tbl[6]  = '{3'd3, 2'd1, 1'b1, 1'b1, 3'd4};
        tbl[7]  = '{3'd4, 2'd1, 1'b1, 1'b0, 3'd4};
        tbl[8]  = '{3'd4, 2'd3, 1'b1, 1'b0, 3'd4};
        tbl[9]  = '{3'd4, 2'd0, 1'b1, 1'b0, 3'd2};
        tbl[10] = '{3'd0, 2'd0, 1'b0, 1'b0, 3'd0};

        // Reset state, with connect already asserted
        rst = 1'b1; connect = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("reset_state", state_o, 3'd0);
        chk("reset_outputs", {usb_dp_o, usb_dn_o, usb_oe_o, sig_active_o, sof_req_o, done_o, cmd_ready_o, wake_o}, 8'h00);
        chk("reset_frame", frame_num_o, 11'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("connect_to_idle", state_o, 3'd1);

        // Command legality table
        for (int i = 0; i < 11; i++) begin
            case (tbl[i].from)
                3'd1: go_idle();
                3'd3: go_active();
                3'd4: go_susp();
                default: hard_reset();
            endcase
            cmd_valid = 1'b1; cmd = tbl[i].c;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready_done", i), {cmd_ready_o, done_o}, {tbl[i].ready, tbl[i].done});
            cyc();
            cmd_valid = 1'b0;
            chk($sformatf("tbl%0d_next", i), state_o, tbl[i].nxt);
        end

        // Bus reset timing from Idle
        go_idle();
        cmd_valid = 1'b1; cmd = 2'd0; us_tick = 1'b1;
        @(negedge clk);
        chk("reset_cmd_handshake", {cmd_ready_o, done_o}, 2'b10);
        cyc();
        cmd_valid = 1'b0;
        run_signal(1'b0);
        chk("busreset_se0_ticks", r_rst, 10);
        chk("busreset_j_cycles", r_j, 32);
        chk("busreset_done_count", r_done, 1);
        chk("busreset_line", r_bad, 0);

        // Two wraps with no ack: one request only
        m_ticks = 0; m_req = 1'b0; m_frame = 0;
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 2 * P + 2; i++) begin
            if (sof_req_o && !prev) rises++;
            prev = sof_req_o;
            sof_step(1'b1, 1'b0);
        end
        chk("two_wrap_single_req", rises, 1);
        sof_step(1'b0, 1'b1);
        chk("ack_frame_inc", frame_num_o, 11'd1);
        chk("ack_req_clear", sof_req_o, 1'b0);
        n = 0;
        while (!sof_req_o && n < 20) begin
            sof_step(1'b1, 1'b0);
            n++;
        end
        chk("next_wrap_gap", n, 6);

        // Randomized ticks and acks against the model
        for (int i = 0; i < 2000; i++) begin
            sof_step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end

        // Advance to frame 2047 and wrap to 0
        n = 0;
        while (m_frame != 2047 && n < 30000) begin
            sof_step(1'b1, 1'b1);
            n++;
        end
        chk("preload_2047", frame_num_o, 11'd2047);
        n = 0;
        while (m_frame != 0 && n < 100) begin
            sof_step(1'b1, 1'b1);
            n++;
        end
        chk("frame_wrap_2047", frame_num_o, 11'd0);
        for (int i = 0; i < 3 * P; i++) sof_step(1'b1, 1'b1);

        // Suspend: quiet line, no SOFs across three frame periods
        us_tick = 1'b0; sof_ack = 1'b0; cmd_valid = 1'b1; cmd = 2'd1;
        @(negedge clk);
        chk("suspend_handshake", {cmd_ready_o, done_o}, 2'b11);
        cyc();
        cmd_valid = 1'b0;
        chk("suspend_state", {state_o, usb_oe_o, sof_req_o}, {3'd4, 1'b0, 1'b0});
        nb = 0;
        for (int i = 0; i < 3 * P + 2; i++) begin
            us_tick = 1'b1;
            @(negedge clk);
            if (sof_req_o || usb_oe_o || done_o || state_o != 3'd4) nb++;
            cyc();
        end
        chk("suspend_quiet", nb, 0);

        // Resume: K, low-speed EOP, J, back to Active
        us_tick = 1'b0; cmd_valid = 1'b1; cmd = 2'd2;
        @(negedge clk);
        chk("resume_handshake", {cmd_ready_o, done_o}, 2'b10);
        cyc();
        cmd_valid = 1'b0;
        chk("resumek_entry", {state_o, usb_oe_o}, {3'd5, 1'b1});
        run_signal(1'b1);
        chk("resume_k_ticks", r_k, 20);
        chk("resume_eop_cycles", r_eop, 64);
        chk("resume_j_cycles", r_j, 32);
        chk("resume_done_count", r_done, 1);
        chk("resume_line", r_bad, 0);
        chk("frame_preserved", frame_num_o, m_frame[10:0]);
        m_ticks = 0; m_req = 1'b0;
        for (int i = 0; i < 5 * P; i++) sof_step(1'b1, 1'b1);

        // Detach in the middle of a bus reset
        sof_ack = 1'b0;
        send_cmd(2'd0);
        us_tick = 1'b1;
        repeat (4) cyc();
        chk("busreset_mid", state_o, 3'd2);
        connect = 1'b0;
        @(negedge clk);
        chk("detach_no_done", done_o, 1'b0);
        cyc();
        @(negedge clk);
        chk("detach_state", {state_o, usb_oe_o, sig_active_o, sof_req_o, done_o}, 7'd0);
        chk("detach_frame", frame_num_o, 11'd0);
        cyc();
        us_tick = 1'b0; cmd_valid = 1'b1; cmd = 2'd0;
        @(negedge clk);
        chk("detached_not_ready", cmd_ready_o, 1'b0);
        cyc();
        cmd_valid = 1'b0;
        chk("detached_stays", state_o, 3'd0);

        // Received K while suspended
        go_susp();
        nw = 0;
        for (int i = 0; i < 7; i++) begin
            rx_dp = 1'b0; rx_dn = 1'b1;
            @(negedge clk);
            if (wake_o) nw++;
            cyc();
        end
        rx_dp = 1'b1; rx_dn = 1'b0;
        @(negedge clk);
        if (wake_o) nw++;
        cyc();
        chk("wake_7_none", nw, 0);
        chk("wake_7_state", state_o, 3'd4);
`ifdef USB_HOST_LINKSIG_WAKE_EN
        nw = 0;
        for (int i = 0; i < 8; i++) begin
            rx_dp = 1'b0; rx_dn = 1'b1;
            @(negedge clk);
            if (wake_o) nw++;
            cyc();
        end
        rx_dp = 1'b1; rx_dn = 1'b0;
        chk("wake_8_pulse", nw, 1);
        chk("wake_resumek", {state_o, usb_oe_o}, {3'd5, 1'b1});
`else
        nw = 0;
        for (int i = 0; i < 20; i++) begin
            rx_dp = 1'b0; rx_dn = 1'b1;
            @(negedge clk);
            if (wake_o) nw++;
            cyc();
        end
        rx_dp = 1'b1; rx_dn = 1'b0;
        chk("wake_disabled_none", nw, 0);
        chk("wake_disabled_state", state_o, 3'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
